multi_cycle_control_unit: RTL and testbench

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

---
 rtl/multi_cycle_control_unit_if.sv | 36 +++
 rtl/multi_cycle_control_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_unit_if.sv
// Control bundle between the multi-cycle control FSM and the RV32I datapath.
// master = control unit (drives strobes), slave = datapath side (drives IR/status).
interface multi_cycle_control_unit_if;
  logic [6:0]  opcode;
  logic        alu_bcond;
  logic        halt_cond;
  logic        mem_ready;

  logic        pc_write;
  logic [1:0]  pc_source;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        is_halted;
  logic [31:0] retire_count;

  modport master (
    input  opcode, alu_bcond, halt_cond, mem_ready,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, is_halted,
           retire_count
  );

  modport slave (
    output opcode, alu_bcond, halt_cond, mem_ready,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, is_halted,
           retire_count
  );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/BR/MEM/WB/HALT) with retired-instruction counter.
// Optional macro MEM_HANDSHAKE_EN: IF and MEM stall until mem_ready; otherwise mem_ready is ignored.
module multi_cycle_control_unit (
  input  logic                        clk,
  input  logic                        reset,
  multi_cycle_control_unit_if.master  bus
);

  typedef enum logic [2:0] {
    st_if   = 3'd0,
    st_id   = 3'd1,
    st_ex   = 3'd2,
    st_br   = 3'd3,
    st_mem  = 3'd4,
    st_wb   = 3'd5,
    st_halt = 3'd6
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       is_halted;
  } ctrl_t;

  localparam logic [1:0] pcsrc_pc4   = 2'd0;
  localparam logic [1:0] pcsrc_alu   = 2'd1;
  localparam logic [1:0] srcb_b      = 2'd0;
  localparam logic [1:0] srcb_imm    = 2'd2;
  localparam logic [1:0] aluop_add   = 2'b00;
  localparam logic [1:0] aluop_br    = 2'b01;
  localparam logic [1:0] aluop_funct = 2'b10;
  localparam logic [1:0] wbsel_alu   = 2'd0;
  localparam logic [1:0] wbsel_mdr   = 2'd1;
  localparam logic [1:0] wbsel_pc4   = 2'd2;

  // Opcode table; index order fixes the meaning of op_match bits below.
  localparam int num_ops = 8;
  localparam logic [6:0] op_codes [num_ops] = '{
    7'b0110011,  // 0 R
    7'b0010011,  // 1 I-arith
    7'b0000011,  // 2 LOAD
    7'b0100011,  // 3 STORE
    7'b1100011,  // 4 BRANCH
    7'b1101111,  // 5 JAL
    7'b1100111,  // 6 JALR
    7'b1110011   // 7 ECALL
  };

  logic [num_ops-1:0] op_match;
  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_ecall;
  logic op_known;
  logic mem_done;

  state_t state_reg, state_next;
  ctrl_t  ctrl_next;
  ctrl_t  ctrl_out;
  logic   halt_enter;
  logic [31:0] retire_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < num_ops; gi++) begin : g_op_match
      assign op_match[gi] = (bus.opcode == op_codes[gi]);
    end
  endgenerate

  assign is_r      = op_match[0];
  assign is_i      = op_match[1];
  assign is_load   = op_match[2];
  assign is_store  = op_match[3];
  assign is_branch = op_match[4];
  assign is_jal    = op_match[5];
  assign is_jalr   = op_match[6];
  assign is_ecall  = op_match[7];
  assign op_known  = |op_match;

`ifdef MEM_HANDSHAKE_EN
  assign mem_done = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= st_if;
    end else begin
      state_reg <= state_next;
    end
  end

  // Every PC update retires one instruction; a halting ECALL retires on entry to HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count_reg <= 32'd0;
    end else if (ctrl_next.pc_write || halt_enter) begin
      retire_count_reg <= retire_count_reg + 32'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    ctrl_next  = '0;
    halt_enter = 1'b0;

    case (state_reg)
      st_if: begin
        ctrl_next.mem_read = 1'b1;
        ctrl_next.i_or_d   = 1'b0;
        if (mem_done) begin
          ctrl_next.ir_write = 1'b1;
          state_next         = st_id;
        end
      end

      st_id: begin
        if (is_ecall && bus.halt_cond) begin
          halt_enter = 1'b1;
          state_next = st_halt;
        end else if (is_ecall || !op_known) begin
          ctrl_next.pc_write  = 1'b1;
          ctrl_next.pc_source = pcsrc_pc4;
          state_next          = st_if;
        end else begin
          state_next = st_ex;
        end
      end

      st_ex: begin
        if (is_r || is_i) begin
          ctrl_next.alu_src_a = 1'b1;
          ctrl_next.alu_src_b = is_i ? srcb_imm : srcb_b;
          ctrl_next.alu_op    = aluop_funct;
          state_next          = st_wb;
        end else if (is_load || is_store) begin
          ctrl_next.alu_src_a = 1'b1;
          ctrl_next.alu_src_b = srcb_imm;
          ctrl_next.alu_op    = aluop_add;
          state_next          = st_mem;
        end else if (is_branch) begin
          ctrl_next.alu_src_a = 1'b1;
          ctrl_next.alu_src_b = srcb_b;
          ctrl_next.alu_op    = aluop_br;
          if (!bus.alu_bcond) begin
            ctrl_next.pc_write  = 1'b1;
            ctrl_next.pc_source = pcsrc_pc4;
            state_next          = st_if;
          end else begin
            state_next = st_br;
          end
        end else if (is_jal || is_jalr) begin
          // Target computed this cycle; link address written back as PC+4.
          ctrl_next.alu_src_a = is_jalr;
          ctrl_next.alu_src_b = srcb_imm;
          ctrl_next.alu_op    = aluop_add;
          ctrl_next.reg_write = 1'b1;
          ctrl_next.wb_sel    = wbsel_pc4;
          ctrl_next.pc_write  = 1'b1;
          ctrl_next.pc_source = pcsrc_alu;
          state_next          = st_if;
        end else begin
          state_next = st_if;
        end
      end

      st_br: begin
        ctrl_next.alu_src_a = 1'b0;
        ctrl_next.alu_src_b = srcb_imm;
        ctrl_next.alu_op    = aluop_add;
        ctrl_next.pc_write  = 1'b1;
        ctrl_next.pc_source = pcsrc_alu;
        state_next          = st_if;
      end

      st_mem: begin
        ctrl_next.i_or_d = 1'b1;
        if (is_load) begin
          ctrl_next.mem_read = 1'b1;
          if (mem_done) begin
            state_next = st_wb;
          end
        end else if (is_store) begin
          ctrl_next.mem_write = 1'b1;
          if (mem_done) begin
            ctrl_next.pc_write  = 1'b1;
            ctrl_next.pc_source = pcsrc_pc4;
            state_next          = st_if;
          end
        end else begin
          state_next = st_if;
        end
      end

      st_wb: begin
        ctrl_next.reg_write = 1'b1;
        ctrl_next.wb_sel    = is_load ? wbsel_mdr : wbsel_alu;
        ctrl_next.pc_write  = 1'b1;
        ctrl_next.pc_source = pcsrc_pc4;
        state_next          = st_if;
      end

      st_halt: begin
        ctrl_next.is_halted = 1'b1;
      end

      default: begin
        state_next = st_if;
      end
    endcase
  end

  // Outputs forced low while reset is high so no write can leak out mid-reset.
  assign ctrl_out = reset ? '0 : ctrl_next;

  assign bus.pc_write     = ctrl_out.pc_write;
  assign bus.pc_source    = ctrl_out.pc_source;
  assign bus.i_or_d       = ctrl_out.i_or_d;
  assign bus.mem_read     = ctrl_out.mem_read;
  assign bus.mem_write    = ctrl_out.mem_write;
  assign bus.ir_write     = ctrl_out.ir_write;
  assign bus.alu_src_a    = ctrl_out.alu_src_a;
  assign bus.alu_src_b    = ctrl_out.alu_src_b;
  assign bus.alu_op       = ctrl_out.alu_op;
  assign bus.reg_write    = ctrl_out.reg_write;
  assign bus.wb_sel       = ctrl_out.wb_sel;
  assign bus.is_halted    = ctrl_out.is_halted;
  assign bus.retire_count = retire_count_reg;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit: per-cycle expected control words queued
// by the stimulus, popped and compared by a negedge monitor.
module tb_multi_cycle_control_unit;

  logic clk = 1'b0;
  logic reset;

  multi_cycle_control_unit_if bus ();

  multi_cycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] op_r      = 7'b0110011;
  localparam logic [6:0] op_i      = 7'b0010011;
  localparam logic [6:0] op_load   = 7'b0000011;
  localparam logic [6:0] op_store  = 7'b0100011;
  localparam logic [6:0] op_branch = 7'b1100011;
  localparam logic [6:0] op_jal    = 7'b1101111;
  localparam logic [6:0] op_jalr   = 7'b1100111;
  localparam logic [6:0] op_ecall  = 7'b1110011;
  localparam logic [6:0] op_bad    = 7'b0000000;

  // Field order: pcw psrc iod mr mw irw sa sb op rw wb halted
  localparam logic [15:0] e_zero        = 16'b0_00_0_0_0_0_0_00_00_0_00_0;
  localparam logic [15:0] e_if          = 16'b0_00_0_1_0_1_0_00_00_0_00_0;
  localparam logic [15:0] e_if_wait     = 16'b0_00_0_1_0_0_0_00_00_0_00_0;
  localparam logic [15:0] e_id_pc4      = 16'b1_00_0_0_0_0_0_00_00_0_00_0;
  localparam logic [15:0] e_ex_r        = 16'b0_00_0_0_0_0_1_00_10_0_00_0;
  localparam logic [15:0] e_ex_i        = 16'b0_00_0_0_0_0_1_10_10_0_00_0;
  localparam logic [15:0] e_ex_mem      = 16'b0_00_0_0_0_0_1_10_00_0_00_0;
  localparam logic [15:0] e_ex_bnt      = 16'b1_00_0_0_0_0_1_00_01_0_00_0;
  localparam logic [15:0] e_ex_bt       = 16'b0_00_0_0_0_0_1_00_01_0_00_0;
  localparam logic [15:0] e_br          = 16'b1_01_0_0_0_0_0_10_00_0_00_0;
  localparam logic [15:0] e_jal         = 16'b1_01_0_0_0_0_0_10_00_1_10_0;
  localparam logic [15:0] e_jalr        = 16'b1_01_0_0_0_0_1_10_00_1_10_0;
  localparam logic [15:0] e_mem_st      = 16'b1_00_1_0_1_0_0_00_00_0_00_0;
  localparam logic [15:0] e_mem_st_wait = 16'b0_00_1_0_1_0_0_00_00_0_00_0;
  localparam logic [15:0] e_mem_ld      = 16'b0_00_1_1_0_0_0_00_00_0_00_0;
  localparam logic [15:0] e_wb_alu      = 16'b1_00_0_0_0_0_0_00_00_1_00_0;
  localparam logic [15:0] e_wb_mdr      = 16'b1_00_0_0_0_0_0_00_00_1_01_0;
  localparam logic [15:0] e_halt        = 16'b0_00_0_0_0_0_0_00_00_0_00_1;

  typedef struct {
    string       name;
    logic [15:0] word;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [15:0] act_w;
  int n_checks = 0;
  int n_errors = 0;

  task automatic step(input string name, input logic [6:0] opc, input logic bc,
                      input logic hc, input logic rdy, input logic rst,
                      input logic [15:0] ew, input logic [31:0] ec);
    exp_t e;
    bus.opcode    = opc;
    bus.alu_bcond = bc;
    bus.halt_cond = hc;
    bus.mem_ready = rdy;
    reset         = rst;
    e.name = name;
    e.word = ew;
    e.cnt  = ec;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // IF is driven with a halting ECALL on the opcode lines: IF must ignore them.
  task automatic fetch(input logic [31:0] c);
    step("IF", op_ecall, 1'b1, 1'b1, 1'b1, 1'b0, e_if, c);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      act_w = {bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
               bus.ir_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
               bus.wb_sel, bus.is_halted};
      n_checks += 2;
      if (act_w !== mon_e.word) begin
        n_errors++;
        $display("FAIL %s ctrl: got %b want %b", mon_e.name, act_w, mon_e.word);
      end
      if (bus.retire_count !== mon_e.cnt) begin
        n_errors++;
        $display("FAIL %s retire_count: got %h want %h", mon_e.name, bus.retire_count, mon_e.cnt);
      end
      $display("t=%0t %s ctrl=%b cnt=%h", $time, mon_e.name, act_w, bus.retire_count);
    end
  end

  initial begin
    reset         = 1'b1;
    bus.opcode    = op_r;
    bus.alu_bcond = 1'b0;
    bus.halt_cond = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("RST", op_r, 1'b0, 1'b0, 1'b1, 1'b1, e_zero, 32'd0);

    // R-type: 4 cycles
    fetch(32'd0);
    step("R.ID", op_r, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd0);
    step("R.EX", op_r, 1'b0, 1'b0, 1'b1, 1'b0, e_ex_r, 32'd0);
    step("R.WB", op_r, 1'b0, 1'b0, 1'b1, 1'b0, e_wb_alu, 32'd0);

    // I-arith: 4 cycles
    fetch(32'd1);
    step("I.ID", op_i, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd1);
    step("I.EX", op_i, 1'b0, 1'b0, 1'b1, 1'b0, e_ex_i, 32'd1);
    step("I.WB", op_i, 1'b0, 1'b0, 1'b1, 1'b0, e_wb_alu, 32'd1);

    // Branch not taken: 3 cycles
    fetch(32'd2);
    step("BNT.ID", op_branch, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd2);
    step("BNT.EX", op_branch, 1'b0, 1'b0, 1'b1, 1'b0, e_ex_bnt, 32'd2);

    // Branch taken: 4 cycles
    fetch(32'd3);
    step("BT.ID", op_branch, 1'b1, 1'b0, 1'b1, 1'b0, e_zero, 32'd3);
    step("BT.EX", op_branch, 1'b1, 1'b0, 1'b1, 1'b0, e_ex_bt, 32'd3);
    step("BT.BR", op_branch, 1'b0, 1'b0, 1'b1, 1'b0, e_br, 32'd3);

    // STORE
    fetch(32'd4);
    step("ST.ID", op_store, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd4);
    step("ST.EX", op_store, 1'b0, 1'b0, 1'b1, 1'b0, e_ex_mem, 32'd4);
`ifdef MEM_HANDSHAKE_EN
    step("ST.MEMW", op_store, 1'b0, 1'b0, 1'b0, 1'b0, e_mem_st_wait, 32'd4);
`endif
    step("ST.MEM", op_store, 1'b0, 1'b0, 1'b1, 1'b0, e_mem_st, 32'd4);

    // LOAD: with handshake, MEM held 3 cycles (7 total); otherwise ready is ignored
    fetch(32'd5);
    step("LD.ID", op_load, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd5);
    step("LD.EX", op_load, 1'b0, 1'b0, 1'b1, 1'b0, e_ex_mem, 32'd5);
`ifdef MEM_HANDSHAKE_EN
    step("LD.MEM1", op_load, 1'b0, 1'b0, 1'b0, 1'b0, e_mem_ld, 32'd5);
    step("LD.MEM2", op_load, 1'b0, 1'b0, 1'b0, 1'b0, e_mem_ld, 32'd5);
    step("LD.MEM3", op_load, 1'b0, 1'b0, 1'b1, 1'b0, e_mem_ld, 32'd5);
`else
    step("LD.MEM", op_load, 1'b0, 1'b0, 1'b0, 1'b0, e_mem_ld, 32'd5);
`endif
    step("LD.WB", op_load, 1'b0, 1'b0, 1'b1, 1'b0, e_wb_mdr, 32'd5);

    // JAL / JALR: 3 cycles each
`ifdef MEM_HANDSHAKE_EN
    step("IF.WAIT", op_ecall, 1'b1, 1'b1, 1'b0, 1'b0, e_if_wait, 32'd6);
`endif
    fetch(32'd6);
    step("JAL.ID", op_jal, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd6);
    step("JAL.EX", op_jal, 1'b0, 1'b0, 1'b1, 1'b0, e_jal, 32'd6);
    fetch(32'd7);
    step("JALR.ID", op_jalr, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd7);
    step("JALR.EX", op_jalr, 1'b0, 1'b0, 1'b1, 1'b0, e_jalr, 32'd7);

    // Non-halting ECALL and unknown opcode: 2 cycles each
    fetch(32'd8);
    step("ECALL.ID", op_ecall, 1'b0, 1'b0, 1'b1, 1'b0, e_id_pc4, 32'd8);
    fetch(32'd9);
    step("BAD.ID", op_bad, 1'b0, 1'b0, 1'b1, 1'b0, e_id_pc4, 32'd9);

    // Reset in MEM of a STORE: no write, no retire, restart at IF
    fetch(32'd10);
    step("STR.ID", op_store, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd10);
    step("STR.EX", op_store, 1'b0, 1'b0, 1'b1, 1'b0, e_ex_mem, 32'd10);
    step("STR.MEMRST", op_store, 1'b0, 1'b0, 1'b1, 1'b1, e_zero, 32'd10);
    fetch(32'd0);
    step("R2.ID", op_r, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd0);
    step("R2.EX", op_r, 1'b0, 1'b0, 1'b1, 1'b0, e_ex_r, 32'd0);
    step("R2.WB", op_r, 1'b0, 1'b0, 1'b1, 1'b0, e_wb_alu, 32'd0);

    // Counter wrap: preload all-ones, a JAL retires to 0
    dut.retire_count_reg = 32'hFFFF_FFFF;
    fetch(32'hFFFF_FFFF);
    step("WRAP.ID", op_jal, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'hFFFF_FFFF);
    step("WRAP.EX", op_jal, 1'b0, 1'b0, 1'b1, 1'b0, e_jal, 32'hFFFF_FFFF);

    // Halting ECALL, 10 cycles parked in HALT with varied inputs, then reset
    fetch(32'd0);
    step("HLT.ID", op_ecall, 1'b0, 1'b1, 1'b1, 1'b0, e_zero, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step("HALT", (i % 2 == 0) ? op_store : op_ecall, i[0], 1'b1, i[1], 1'b0, e_halt, 32'd1);
    end
    step("HLT.RST", op_r, 1'b0, 1'b0, 1'b1, 1'b1, e_zero, 32'd1);
    fetch(32'd0);
    step("R3.ID", op_r, 1'b0, 1'b0, 1'b1, 1'b0, e_zero, 32'd0);
    step("R3.EX", op_r, 1'b0, 1'b0, 1'b1, 1'b0, e_ex_r, 32'd0);
    step("R3.WB", op_r, 1'b0, 1'b0, 1'b1, 1'b0, e_wb_alu, 32'd0);
    fetch(32'd1);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #2;
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
